// File: rtl/kw_ram_1rws_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package KW_ram_arb_pkg;
    localparam int ARB_PORTS = 2;

    typedef logic [((ARB_PORTS > 1) ? $clog2(ARB_PORTS) : 1)-1:0] port_idx_t;

    // Round-robin pointer advance: the port after g, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction
endpackage

// File: rtl/kw_ram_1rws_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among req, search starts at rr_ptr.
module KW_arb_rr
    import KW_ram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gidx;
    logic [IW-1:0] k;
    int            kk;

    always_comb begin
        grant = '0;
        gidx  = '0;
        k     = '0;
        kk    = 0;
        for (int i = 0; i < N; i++) begin
            kk = int'(rr_ptr) + i;
            if (kk >= N) kk = kk - N;
            k = IW'(kk);
            if (req[k] && grant == '0) begin
                grant[k] = 1'b1;
                gidx     = k;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= IW'(rr_next(32'(gidx), N));
    end
endmodule

// File: rtl/kw_ram_1rws_arbiter.sv
// Shares one single-port sync RAM among NUM_PORTS requesters; read data
// returns through a one-entry buffer per port.
module kw_ram_1rws_arbiter
    import KW_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    output logic [NUM_PORTS-1:0]                  req_ready,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]                  rsp_valid,
    input  logic [NUM_PORTS-1:0]                  rsp_ready,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata,
    output logic                                  mem_cs_n,
    output logic                                  mem_we_n,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [IW-1:0]        gidx;
    logic                 rd_inflight;
    logic [IW-1:0]        rd_idx;

    // A read needs its buffer free (or freeing now) and no read of its own
    // still at the RAM; reset gating keeps the RAM idle while reset is high.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = !reset && req_valid[p] &&
                          (req_write[p] ||
                           (!(rd_inflight && rd_idx == IW'(p)) &&
                            (!rsp_valid[p] || rsp_ready[p])));
        end
    end

    KW_arb_rr #(.N(NUM_PORTS)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (eligible),
        .grant   (grant),
        .advance (|grant)
    );

    always_comb begin
        gidx = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (grant[p]) gidx = IW'(p);
    end

    assign req_ready = grant;
    assign mem_cs_n  = !(|grant);
    assign mem_we_n  = !(|(grant & req_write));
    assign mem_addr  = req_addr[gidx];
    assign mem_wdata = req_wdata[gidx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_inflight <= 1'b0;
            rd_idx      <= '0;
        end else begin
            rd_inflight <= |(grant & ~req_write);
            rd_idx      <= gidx;
        end
    end

    // A capture wins over a pop at the same edge, so the entry stays valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_inflight && rd_idx == IW'(p)) begin
                    rsp_valid[p] <= 1'b1;
                    rsp_rdata[p] <= mem_rdata;
                end else if (rsp_ready[p]) begin
                    rsp_valid[p] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_kw_ram_1rws_arbiter.sv
// Directed bench for kw_ram_1rws_arbiter with a behavioural single-port RAM.
module tb_kw_ram_1rws_arbiter;
    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NP-1:0]          req_valid, req_ready, req_write;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][DW-1:0]  req_wdata;
    logic [NP-1:0]          rsp_valid, rsp_ready;
    logic [NP-1:0][DW-1:0]  rsp_rdata;
    logic                   mem_cs_n, mem_we_n;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata, mem_rdata;
    logic [DW-1:0]          ram [256];

    int checks = 0;
    int errors = 0;

    kw_ram_1rws_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEPTH(256)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!mem_cs_n) begin
            if (!mem_we_n) ram[mem_addr] <= mem_wdata;
            else           mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic drive(input int p, input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req_valid[p] = v;
        req_write[p] = w;
        req_addr[p]  = a;
        req_wdata[p] = d;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        checks++; if (mem_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got=%b exp=1", mem_cs_n); end
        checks++; if (mem_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got=%b exp=1", mem_we_n); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
        @(negedge clock);
        reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single;
        @(negedge clock); drive(0, 1, 1, 8'd5, 32'hDEADBEEF); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_wr_ready got=%b exp=01", req_ready); end
        checks++; if (mem_we_n !== 1'b0 || mem_cs_n !== 1'b0) begin errors++; $display("FAIL single_wr_ctl got=cs%b we%b exp=cs0 we0", mem_cs_n, mem_we_n); end
        checks++; if (mem_addr !== 8'd5) begin errors++; $display("FAIL single_wr_addr got=%0d exp=5", mem_addr); end
        @(negedge clock); drive(0, 1, 0, 8'd5, 32'h0); #1;
        checks++; if (req_ready !== 2'b01 || mem_we_n !== 1'b1) begin errors++; $display("FAIL single_rd_grant got=rdy%b we%b exp=rdy01 we1", req_ready, mem_we_n); end
        @(negedge clock); req_valid = '0; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_t1_valid got=%b exp=00", rsp_valid); end
        @(negedge clock); #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_t2_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", rsp_rdata[0]); end
        rsp_ready = 2'b01;
        @(negedge clock); #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_pop got=%b exp=00", rsp_valid); end
        rsp_ready = 2'b00;
    endtask

    // Last grant was port 0, so the pointer sits at 1 and port 1 goes first.
    task automatic test_fairness;
        logic [NP-1:0] exp_g;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive(0, 1, 1, 8'd20, 32'h100 + i);
            drive(1, 1, 1, 8'd21, 32'h200 + i);
            #1;
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL fair_grant[%0d] got=%b exp=%b", i, req_ready, exp_g); end
            checks++; if (mem_cs_n !== 1'b0) begin errors++; $display("FAIL fair_cs_n[%0d] got=%b exp=0", i, mem_cs_n); end
            checks++; if (mem_addr !== ((i % 2 == 0) ? 8'd21 : 8'd20)) begin errors++; $display("FAIL fair_addr[%0d] got=%0d", i, mem_addr); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        @(negedge clock); drive(0, 1, 1, 8'd3, 32'h11); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_wr_ready got=%b exp=01", req_ready); end
        @(negedge clock); drive(0, 1, 0, 8'd3, 32'h0); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_rd1_grant got=%b exp=01", req_ready); end
        @(negedge clock); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_inflight_block got=%b exp=00", req_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h11) begin errors++; $display("FAIL bp_hold[%0d] got=v%b d%h exp=v1 d11", i, rsp_valid[0], rsp_rdata[0]); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_block[%0d] got=%b exp=00", i, req_ready); end
        end
        @(negedge clock); rsp_ready = 2'b01; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_rd2_grant got=%b exp=01", req_ready); end
        @(negedge clock); req_valid = '0; #1;
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_popped got=%b exp=0", rsp_valid[0]); end
        @(negedge clock); #1;
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h11) begin errors++; $display("FAIL bp_rd2_rsp got=v%b d%h exp=v1 d11", rsp_valid[0], rsp_rdata[0]); end
        @(negedge clock); rsp_ready = 2'b00; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_drain got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_collision;
        rsp_ready = 2'b01;
        @(negedge clock); drive(0, 1, 1, 8'd1, 32'hA);
        @(negedge clock); drive(0, 1, 1, 8'd2, 32'hB);
        @(negedge clock); drive(0, 1, 0, 8'd1, 32'h0); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL col_rd1 got=%b exp=01", req_ready); end
        @(negedge clock); drive(0, 1, 0, 8'd2, 32'h0); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL col_gap got=%b exp=00", req_ready); end
        @(negedge clock); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL col_rd2 got=%b exp=01", req_ready); end
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hA) begin errors++; $display("FAIL col_rsp1 got=v%b d%h exp=v1 da", rsp_valid[0], rsp_rdata[0]); end
        @(negedge clock); req_valid = '0; #1;
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL col_mid got=%b exp=0", rsp_valid[0]); end
        @(negedge clock); #1;
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hB) begin errors++; $display("FAIL col_rsp2 got=v%b d%h exp=v1 db", rsp_valid[0], rsp_rdata[0]); end
        @(negedge clock); #1;
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL col_end got=%b exp=0", rsp_valid[0]); end
        rsp_ready = 2'b00;
    endtask

    task automatic test_rw_mix;
        @(negedge clock); drive(1, 1, 1, 8'd7, 32'h55); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mix_pre got=%b exp=10", req_ready); end
        @(negedge clock); drive(1, 1, 0, 8'd7, 32'h0); drive(0, 1, 1, 8'd7, 32'h77); #1;
        checks++; if (req_ready !== 2'b01 || mem_we_n !== 1'b0 || mem_wdata !== 32'h77) begin errors++; $display("FAIL mix_wr_first got=rdy%b we%b d%h exp=rdy01 we0 d77", req_ready, mem_we_n, mem_wdata); end
        @(negedge clock); req_valid[0] = 1'b0; #1;
        checks++; if (req_ready !== 2'b10 || mem_we_n !== 1'b1) begin errors++; $display("FAIL mix_rd_next got=rdy%b we%b exp=rdy10 we1", req_ready, mem_we_n); end
        @(negedge clock); req_valid = '0; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mix_t1 got=%b exp=00", rsp_valid); end
        @(negedge clock); #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata[1] !== 32'h77) begin errors++; $display("FAIL mix_rsp got=v%b d%h exp=v10 d77", rsp_valid, rsp_rdata[1]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clock); drive(0, 1, 0, 8'd5, 32'h0); drive(1, 0, 0, 8'd0, 32'h0); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant got=%b exp=01", req_ready); end
        @(negedge clock); reset = 1'b1; drive(1, 1, 0, 8'd7, 32'h0); #1;
        checks++; if (req_ready !== 2'b00 || mem_cs_n !== 1'b1 || mem_we_n !== 1'b1) begin errors++; $display("FAIL midrst_ctl got=rdy%b cs%b we%b exp=rdy00 cs1 we1", req_ready, mem_cs_n, mem_we_n); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_valid got=%b exp=00", rsp_valid); end
        @(negedge clock); #1;
        checks++; if (req_ready !== 2'b00 || mem_cs_n !== 1'b1) begin errors++; $display("FAIL midrst_hold got=rdy%b cs%b exp=rdy00 cs1", req_ready, mem_cs_n); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", rsp_rdata); end
        @(negedge clock); reset = 1'b0; req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp[%0d] got=%b exp=00", i, rsp_valid); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        test_reset;
        test_single;
        test_fairness;
        test_backpressure;
        test_collision;
        test_rw_mix;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
